// File: rtl/counter_table_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : counter_table_ctrl
// Desc     : Single-port sequencer for the 128x3b saturating counter table:
//            lookup/update arbitration, saturating RMW and global attenuation.
// Revision : 1.0 - initial release
// ============================================================================
module counter_table_ctrl #(
    parameter int ATTEN_PERIOD = 1024,
    parameter int STARVE_LIMIT = 8
) (
    input  logic       Clk,
    input  logic       Rest,
    input  logic       LkValid,
    input  logic [6:0] LkAddr,
    output logic       LkReady,
    output logic       LkRspValid,
    output logic [2:0] LkRspData,
    input  logic       UpValid,
    input  logic [6:0] UpAddr,
    input  logic       UpAlloc,
    input  logic       UpInc,
    input  logic [2:0] UpVal,
    output logic       UpReady,
    input  logic       AttenReq,
    output logic       TblAtten,
    output logic [6:0] TblAddr,
    output logic       TblWen,
    output logic [2:0] TblDin,
    input  logic [2:0] TblDout
);
    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_UP_WR = 1'b1;
    localparam int c_SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [c_SW-1:0] c_STARVE_MAX = c_SW'(STARVE_LIMIT);

    logic [0:0]      r_state;
    logic [0:0]      w_state_nxt;
    logic            r_atten_pend;
    logic [c_SW-1:0] r_starve_cnt;
    logic            r_lk_rsp_valid;
    logic [6:0]      r_up_addr;
    logic            r_up_inc;
    logic            w_period_exp;
    logic            w_idle;
    logic            w_gnt_atten;
    logic            w_gnt_up;
    logic            w_gnt_lk;
    logic [2:0]      w_rmw_data;

    generate
        if (ATTEN_PERIOD > 0) begin : g_period
            localparam int c_PW = (ATTEN_PERIOD > 1) ? $clog2(ATTEN_PERIOD) : 1;
            localparam logic [c_PW-1:0] c_PERIOD_MAX = c_PW'(ATTEN_PERIOD - 1);
            logic [c_PW-1:0] r_period_cnt;

            always_ff @(posedge Clk or posedge Rest) begin
                if (Rest) begin
                    r_period_cnt <= '0;
                end else if (r_period_cnt == c_PERIOD_MAX) begin
                    r_period_cnt <= '0;
                end else begin
                    r_period_cnt <= r_period_cnt + c_PW'(1);
                end
            end

            assign w_period_exp = (r_period_cnt == c_PERIOD_MAX);
        end else begin : g_no_period
            assign w_period_exp = 1'b0;
        end
    endgenerate

    // Priority in IDLE: attenuation, then (possibly starved) update, then lookup.
    assign w_idle      = (r_state == c_IDLE);
    assign w_gnt_atten = w_idle & r_atten_pend;
    assign w_gnt_up    = w_idle & ~r_atten_pend & UpValid &
                         ((r_starve_cnt >= c_STARVE_MAX) | ~LkValid);
    assign w_gnt_lk    = w_idle & ~r_atten_pend & ~w_gnt_up & LkValid;

    assign w_rmw_data = r_up_inc ? ((TblDout == 3'd7) ? 3'd7 : TblDout + 3'd1)
                                 : ((TblDout == 3'd0) ? 3'd0 : TblDout - 3'd1);

    always_ff @(posedge Clk or posedge Rest) begin
        if (Rest) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_gnt_up && !UpAlloc) w_state_nxt = c_UP_WR;
            c_UP_WR: w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Outputs are forced low while reset is held so no write can escape mid-RMW.
    always_comb begin
        LkReady  = 1'b0;
        UpReady  = 1'b0;
        TblAtten = 1'b0;
        TblAddr  = '0;
        TblWen   = 1'b0;
        TblDin   = '0;
        if (!Rest) begin
            if (r_state == c_UP_WR) begin
                TblAddr = r_up_addr;
                TblWen  = 1'b1;
                TblDin  = w_rmw_data;
            end else if (w_gnt_atten) begin
                TblAtten = 1'b1;
            end else if (w_gnt_up) begin
                UpReady = 1'b1;
                TblAddr = UpAddr;
                TblWen  = UpAlloc;
                TblDin  = UpAlloc ? UpVal : 3'd0;
            end else if (w_gnt_lk) begin
                LkReady = 1'b1;
                TblAddr = LkAddr;
            end
        end
    end

    assign LkRspValid = r_lk_rsp_valid;
    assign LkRspData  = r_lk_rsp_valid ? TblDout : 3'd0;

    always_ff @(posedge Clk or posedge Rest) begin
        if (Rest) begin
            r_atten_pend   <= 1'b0;
            r_starve_cnt   <= '0;
            r_lk_rsp_valid <= 1'b0;
            r_up_addr      <= '0;
            r_up_inc       <= 1'b0;
        end else begin
            r_lk_rsp_valid <= w_gnt_lk;
            // A new request in the same cycle as the grant keeps it pending.
            if (AttenReq || w_period_exp) begin
                r_atten_pend <= 1'b1;
            end else if (w_gnt_atten) begin
                r_atten_pend <= 1'b0;
            end
            if (!UpValid || w_gnt_up) begin
                r_starve_cnt <= '0;
            end else if (r_starve_cnt != c_STARVE_MAX) begin
                r_starve_cnt <= r_starve_cnt + c_SW'(1);
            end
            if (w_gnt_up && !UpAlloc) begin
                r_up_addr <= UpAddr;
                r_up_inc  <= UpInc;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_counter_table_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_table_ctrl
// Desc     : Directed bench for counter_table_ctrl with a table model and a
//            request-level reference model checked every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_table_ctrl;
    localparam int ATTEN_PERIOD = 16;
    localparam int STARVE_LIMIT = 8;

    logic       Clk      = 1'b0;
    logic       Rest     = 1'b1;
    logic       LkValid  = 1'b0;
    logic [6:0] LkAddr   = '0;
    logic       UpValid  = 1'b0;
    logic [6:0] UpAddr   = '0;
    logic       UpAlloc  = 1'b0;
    logic       UpInc    = 1'b0;
    logic [2:0] UpVal    = '0;
    logic       AttenReq = 1'b0;
    logic [2:0] TblDout  = '0;
    logic       LkReady, LkRspValid, UpReady, TblAtten, TblWen;
    logic [2:0] LkRspData, TblDin;
    logic [6:0] TblAddr;

    int n_vec = 0;
    int n_err = 0;

    counter_table_ctrl #(
        .ATTEN_PERIOD(ATTEN_PERIOD),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_dut (
        .Clk(Clk), .Rest(Rest),
        .LkValid(LkValid), .LkAddr(LkAddr), .LkReady(LkReady),
        .LkRspValid(LkRspValid), .LkRspData(LkRspData),
        .UpValid(UpValid), .UpAddr(UpAddr), .UpAlloc(UpAlloc), .UpInc(UpInc),
        .UpVal(UpVal), .UpReady(UpReady), .AttenReq(AttenReq),
        .TblAtten(TblAtten), .TblAddr(TblAddr), .TblWen(TblWen),
        .TblDin(TblDin), .TblDout(TblDout)
    );

    always #5 Clk = ~Clk;

    // Table: registered read, write-enable, global saturating decrement.
    logic [2:0] tbl_mem [128] = '{default: 3'd0};
    always @(posedge Clk) begin
        if (TblAtten) begin
            for (int i = 0; i < 128; i++) tbl_mem[i] <= (tbl_mem[i] == 3'd0) ? 3'd0 : tbl_mem[i] - 3'd1;
        end else begin
            TblDout <= tbl_mem[TblAddr];
            if (TblWen) tbl_mem[TblAddr] <= TblDin;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Reference: what each cycle must do, tracked at the request level.
    int m_per = 0;
    bit m_rmw = 0;
    int m_rmw_addr = 0;
    bit m_rmw_inc = 0;
    bit m_pend = 0;
    int m_starve = 0;
    bit m_rsp = 0;
    int m_rsp_val = 0;
    int exp_mem [128] = '{default: 0};

    always @(negedge Clk) begin : p_model
        bit e_lkr, e_upr, e_att, e_wen, e_fire;
        int e_addr, e_din, v;
        if (Rest) begin
            chk("rst lkready", LkReady, 0);
            chk("rst upready", UpReady, 0);
            chk("rst atten", TblAtten, 0);
            chk("rst wen", TblWen, 0);
            chk("rst rspvalid", LkRspValid, 0);
            chk("rst rspdata", LkRspData, 0);
            m_per = 0; m_rmw = 0; m_pend = 0; m_starve = 0; m_rsp = 0;
        end else begin
            e_lkr = 0; e_upr = 0; e_att = 0; e_wen = 0; e_addr = 0; e_din = 0;
            e_fire = (m_per == ATTEN_PERIOD - 1);
            if (m_rmw) begin
                v = exp_mem[m_rmw_addr];
                e_wen = 1; e_addr = m_rmw_addr;
                e_din = m_rmw_inc ? ((v < 7) ? v + 1 : 7) : ((v > 0) ? v - 1 : 0);
            end else if (m_pend) begin
                e_att = 1;
            end else if (UpValid && (m_starve >= STARVE_LIMIT || !LkValid)) begin
                e_upr = 1; e_addr = int'(UpAddr); e_wen = UpAlloc; e_din = int'(UpVal);
            end else if (LkValid) begin
                e_lkr = 1; e_addr = int'(LkAddr);
            end
            chk("lkready", LkReady, e_lkr);
            chk("upready", UpReady, e_upr);
            chk("atten", TblAtten, e_att);
            chk("wen", TblWen, e_wen);
            chk("rspvalid", LkRspValid, m_rsp);
            chk("rspdata", LkRspData, m_rsp ? m_rsp_val : 0);
            if (e_wen || e_lkr || e_upr) chk("addr", TblAddr, e_addr);
            if (e_wen) chk("din", TblDin, e_din);

            m_rsp = e_lkr;
            if (e_lkr) m_rsp_val = exp_mem[LkAddr];
            if (m_rmw) begin
                exp_mem[m_rmw_addr] = e_din;
                m_rmw = 0;
            end else if (e_att) begin
                for (int i = 0; i < 128; i++) if (exp_mem[i] > 0) exp_mem[i] = exp_mem[i] - 1;
            end else if (e_upr) begin
                if (UpAlloc) exp_mem[UpAddr] = int'(UpVal);
                else begin
                    m_rmw = 1; m_rmw_addr = int'(UpAddr); m_rmw_inc = UpInc;
                end
            end
            m_pend   = (AttenReq || e_fire) ? 1'b1 : (e_att ? 1'b0 : m_pend);
            m_starve = (UpValid && !e_upr) ? ((m_starve < STARVE_LIMIT) ? m_starve + 1 : STARVE_LIMIT) : 0;
            m_per    = (m_per + 1) % ATTEN_PERIOD;
        end
    end

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        LkValid = 0; UpValid = 0; UpAlloc = 0; UpInc = 0; AttenReq = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        Rest = 1;
        cyc(); cyc();
        Rest = 0;
    endtask

    task automatic alloc(input int a, input int v);
        UpValid = 1; UpAlloc = 1; UpAddr = 7'(a); UpVal = 3'(v);
        cyc();
        UpValid = 0; UpAlloc = 0;
    endtask

    initial begin
        cyc(); cyc(); cyc();
        Rest = 0;

        // Allocations then back-to-back lookups
        alloc(5, 3); alloc(6, 7);
        LkValid = 1; LkAddr = 5; cyc();
        LkAddr = 6; #1;
        chk("t2 rsp5 valid", LkRspValid, 1); chk("t2 rsp5 data", LkRspData, 3); chk("t2 lkready", LkReady, 1);
        cyc();
        LkValid = 0; #1;
        chk("t2 rsp6 valid", LkRspValid, 1); chk("t2 rsp6 data", LkRspData, 7);
        cyc();
        #1 chk("t2 rsp idle", LkRspValid, 0);

        // Saturating read-modify-write
        do_reset();
        alloc(10, 7); alloc(11, 0); alloc(12, 3);
        UpValid = 1; UpAlloc = 0; UpAddr = 10; UpInc = 1; #1;
        chk("t3 rd upready", UpReady, 1); chk("t3 rd wen", TblWen, 0);
        cyc();
        UpValid = 0; LkValid = 1; LkAddr = 10; #1;
        chk("t3 wr wen", TblWen, 1); chk("t3 inc sat din", TblDin, 7); chk("t3 wr lkready", LkReady, 0);
        cyc();
        LkValid = 0; UpValid = 1; UpAddr = 11; UpInc = 0; cyc();
        UpValid = 0; #1;
        chk("t3 dec wen", TblWen, 1); chk("t3 dec sat din", TblDin, 0);
        cyc();
        UpValid = 1; UpAddr = 12; UpInc = 1; cyc();
        UpValid = 0; #1;
        chk("t3 inc din", TblDin, 4);
        cyc();
        LkValid = 1; LkAddr = 10; cyc();
        LkAddr = 11; #1 chk("t3 lk10", LkRspData, 7); cyc();
        LkAddr = 12; #1 chk("t3 lk11", LkRspData, 0); cyc();
        LkValid = 0; #1 chk("t3 lk12", LkRspData, 4); cyc();

        // Starvation override against continuous lookups
        do_reset();
        LkValid = 1; LkAddr = 5;
        UpValid = 1; UpAlloc = 0; UpAddr = 20; UpInc = 1;
        for (int i = 0; i < 9; i++) begin
            #1;
            chk("t4 upready", UpReady, (i == 8));
            chk("t4 lkready", LkReady, (i != 8));
            cyc();
        end
        UpValid = 0; #1;
        chk("t4 wr lkready", LkReady, 0); chk("t4 wr wen", TblWen, 1); chk("t4 wr din", TblDin, 1);
        cyc();
        #1 chk("t4 lk resumes", LkReady, 1);
        cyc();
        LkValid = 0; #1 chk("t4 rsp", LkRspData, 3);
        cyc();

        // Periodic and requested attenuation
        do_reset();
        for (int i = 0; i < 41; i++) begin
            UpValid  = (i == 0) || (i == 20);
            UpAlloc  = (i == 0);
            UpAddr   = (i == 0) ? 7'd12 : 7'd30;
            UpVal    = 3'd4;
            UpInc    = 1;
            LkValid  = (i == 17) || (i == 24);
            LkAddr   = 12;
            AttenReq = (i == 21);
            #1;
            chk("t5 atten", TblAtten, (i == 16) || (i == 22) || (i == 32));
            if (i == 18) chk("t5 idx12 after 1 atten", LkRspData, 3);
            if (i == 25) chk("t5 idx12 after 2 atten", LkRspData, 2);
            cyc();
        end
        idle_inputs();

        // Reset in the middle of an RMW
        do_reset();
        alloc(40, 5);
        UpValid = 1; UpAlloc = 0; UpAddr = 40; UpInc = 1; cyc();
        LkValid = 1; LkAddr = 40; #1;
        chk("t6 wr before rst", TblWen, 1);
        Rest = 1; #1;
        chk("t6 wen in rst", TblWen, 0); chk("t6 lkready in rst", LkReady, 0);
        chk("t6 upready in rst", UpReady, 0); chk("t6 rspvalid in rst", LkRspValid, 0);
        UpValid = 0;
        cyc(); cyc();
        Rest = 0; #1;
        chk("t6 lkready after rst", LkReady, 1);
        cyc();
        LkValid = 0; #1;
        chk("t6 rsp valid", LkRspValid, 1); chk("t6 pre-rmw value", LkRspData, 5);
        cyc(); cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
